// File: rtl/stage_ex_pkg.sv
// Shared widths, opcode encodings and FSM states for the execute stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage_ex_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int DATA_ADDR_W = 32;
    localparam int ALU_OP_W    = 4;
    localparam int SHAMT_W     = $clog2(DATA_W);

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIVU = 4'd11,
        ALU_REMU = 4'd12
    } alu_op_e;

    typedef enum logic {
        EX_IDLE = 1'b0,
        EX_BUSY = 1'b1
    } ex_state_e;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_kind_e;

    // Ops that go through the iterative unit instead of the single-cycle ALU.
    function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/stage_ex_if.sv
// Decode-side inputs and STAGE_MM-side outputs of the execute stage.
// Latency: n/a (wiring only).
// Backpressure: ex_busy tells upstream to hold the instruction bus.
interface stage_ex_if;

    logic                                  en;
    logic                                  stall;
    logic                                  flush;
    logic [stage_ex_pkg::ALU_OP_W-1:0]     alu_op;
    logic                                  is_load;
    logic                                  is_store;
    logic                                  reg_wr;
    logic                                  use_imm;
    logic [stage_ex_pkg::REG_ADDR_W-1:0]   reg_addr_rd;
    logic [stage_ex_pkg::DATA_W-1:0]       rs1_data;
    logic [stage_ex_pkg::DATA_W-1:0]       rs2_data;
    logic [stage_ex_pkg::DATA_W-1:0]       imm;
    logic [1:0]                            fwd_sel_a;
    logic [1:0]                            fwd_sel_b;
    logic [stage_ex_pkg::DATA_W-1:0]       ffw_MM_data_wr;
    logic [stage_ex_pkg::DATA_W-1:0]       ffw_WB_data_wr;

    logic                                  ex_busy;
    logic                                  out_is_load;
    logic                                  out_is_store;
    logic                                  out_reg_wr;
    logic [stage_ex_pkg::REG_ADDR_W-1:0]   out_reg_addr_rd;
    logic [stage_ex_pkg::DATA_W-1:0]       out_reg_data_rd;
    logic [stage_ex_pkg::DATA_ADDR_W-1:0]  out_alu_mem_addr;
    logic                                  out_flush;

    modport master (
        output en, stall, flush, alu_op, is_load, is_store, reg_wr, use_imm,
               reg_addr_rd, rs1_data, rs2_data, imm, fwd_sel_a, fwd_sel_b,
               ffw_MM_data_wr, ffw_WB_data_wr,
        input  ex_busy, out_is_load, out_is_store, out_reg_wr, out_reg_addr_rd,
               out_reg_data_rd, out_alu_mem_addr, out_flush
    );

    modport slave (
        input  en, stall, flush, alu_op, is_load, is_store, reg_wr, use_imm,
               reg_addr_rd, rs1_data, rs2_data, imm, fwd_sel_a, fwd_sel_b,
               ffw_MM_data_wr, ffw_WB_data_wr,
        output ex_busy, out_is_load, out_is_store, out_reg_wr, out_reg_addr_rd,
               out_reg_data_rd, out_alu_mem_addr, out_flush
    );

endinterface

// File: rtl/stage_ex_muldiv.sv
// Iterative unit: shift-add multiply and restoring divide, one bit per step.
// Latency: DATA_W steps after start; result is combinational on the last step.
// Backpressure: only advances when the parent asserts step.
module stage_ex_muldiv
    import stage_ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  md_kind_e          kind,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    // d_q: multiplicand (shifted left) or divisor; x_q: multiplier or
    // dividend/quotient; acc_q: partial product or partial remainder.
    md_kind_e             kind_q;
    logic [DATA_W-1:0]    d_q, x_q, acc_q;
    logic [DATA_W-1:0]    d_n, x_n, acc_n;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [DATA_W:0]      rem_sh;
    logic [DATA_W-1:0]    rem_diff;
    logic                 ge;

    // One iteration of the selected algorithm from the current registers.
    always_comb begin
        rem_sh   = {acc_q, x_q[DATA_W-1]};
        rem_diff = rem_sh[DATA_W-1:0] - d_q;
        ge       = (rem_sh >= {1'b0, d_q});
        d_n      = d_q;
        x_n      = x_q;
        acc_n    = acc_q;
        if (kind_q == MD_MUL) begin
            acc_n = acc_q + (x_q[0] ? d_q : '0);
            d_n   = d_q << 1;
            x_n   = x_q >> 1;
        end else begin
            // A zero divisor always "fits", giving all-ones quotient and the
            // dividend as remainder without special casing.
            acc_n = ge ? rem_diff : rem_sh[DATA_W-1:0];
            x_n   = {x_q[DATA_W-2:0], ge};
        end
        result = (kind_q == MD_DIVU) ? x_n : acc_n;
        done   = (cnt_q == SHAMT_W'(DATA_W-1));
    end

    // Operand load on start, one iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q <= MD_MUL;
            d_q    <= '0;
            x_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            kind_q <= kind;
            d_q    <= opb;
            x_q    <= opa;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (step) begin
            d_q    <= d_n;
            x_q    <= x_n;
            acc_q  <= acc_n;
            cnt_q  <= cnt_q + SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/stage_ex.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative mul/div.
// Latency: 1 edge for ALU/load/store; DATA_W edges after issue for mul/div.
// Backpressure: ex_busy holds upstream; stall/en=0 freeze outputs.
module stage_ex
    import stage_ex_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    stage_ex_if.slave bus
);

    ex_state_e               state_q, state_n;
    logic [DATA_W-1:0]       opa, opbf, opb, alu_res, addr_sum;
    logic                    is_md;
    md_kind_e                md_kind;
    logic                    md_start, md_step, md_done;
    logic [DATA_W-1:0]       md_result;
    logic                    ld_alu, ld_bub, ld_res;
    logic [REG_ADDR_W-1:0]   rd_save_q;

    logic                    out_is_load_q, out_is_store_q, out_reg_wr_q, out_flush_q;
    logic [REG_ADDR_W-1:0]   out_reg_addr_rd_q;
    logic [DATA_W-1:0]       out_reg_data_rd_q;
    logic [DATA_ADDR_W-1:0]  out_alu_mem_addr_q;

    // Forwarding mux; select 3 falls back to the decode operand.
    always_comb begin
        case (bus.fwd_sel_a)
            2'd1:    opa = bus.ffw_MM_data_wr;
            2'd2:    opa = bus.ffw_WB_data_wr;
            default: opa = bus.rs1_data;
        endcase
        case (bus.fwd_sel_b)
            2'd1:    opbf = bus.ffw_MM_data_wr;
            2'd2:    opbf = bus.ffw_WB_data_wr;
            default: opbf = bus.rs2_data;
        endcase
        opb      = bus.use_imm ? bus.imm : opbf;
        addr_sum = opa + bus.imm;
    end

    // Single-cycle ALU; mul/div codes produce nothing here.
    always_comb begin
        alu_res = '0;
        case (alu_op_e'(bus.alu_op))
            ALU_ADD:  alu_res = opa + opb;
            ALU_SUB:  alu_res = opa - opb;
            ALU_AND:  alu_res = opa & opb;
            ALU_OR:   alu_res = opa | opb;
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_SLL:  alu_res = opa << opb[SHAMT_W-1:0];
            ALU_SRL:  alu_res = opa >> opb[SHAMT_W-1:0];
            ALU_SRA:  alu_res = $unsigned($signed(opa) >>> opb[SHAMT_W-1:0]);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(opa) < $signed(opb)};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, opa < opb};
            default:  alu_res = '0;
        endcase
    end

    // Which iterative algorithm the incoming op needs.
    always_comb begin
        is_md   = is_muldiv(bus.alu_op);
        md_kind = MD_MUL;
        if (bus.alu_op == ALU_DIVU) begin
            md_kind = MD_DIVU;
        end else if (bus.alu_op == ALU_REMU) begin
            md_kind = MD_REMU;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EX_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // FSM next state and load strobes for the output registers.
    always_comb begin
        state_n  = state_q;
        md_start = 1'b0;
        md_step  = 1'b0;
        ld_alu   = 1'b0;
        ld_bub   = 1'b0;
        ld_res   = 1'b0;
        case (state_q)
            EX_IDLE: begin
                if (bus.en && !bus.stall) begin
                    if (bus.flush) begin
                        ld_bub = 1'b1;
                    end else if (is_md) begin
                        ld_bub   = 1'b1;
                        md_start = 1'b1;
                        state_n  = EX_BUSY;
                    end else begin
                        ld_alu = 1'b1;
                    end
                end
            end
            EX_BUSY: begin
                // Stall only matters on the final step, where the result
                // would overwrite outputs STAGE_MM has not yet taken.
                if (bus.en) begin
                    if (!md_done) begin
                        md_step = 1'b1;
                    end else if (!bus.stall) begin
                        md_step = 1'b1;
                        ld_res  = 1'b1;
                        state_n = EX_IDLE;
                    end
                end
            end
            default: state_n = EX_IDLE;
        endcase
    end

    stage_ex_muldiv ex_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .step   (md_step),
        .kind   (md_kind),
        .opa    (opa),
        .opb    (opb),
        .done   (md_done),
        .result (md_result)
    );

    // Output registers toward STAGE_MM plus the saved mul/div destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_is_load_q      <= 1'b0;
            out_is_store_q     <= 1'b0;
            out_reg_wr_q       <= 1'b0;
            out_flush_q        <= 1'b1;
            out_reg_addr_rd_q  <= '0;
            out_reg_data_rd_q  <= '0;
            out_alu_mem_addr_q <= '0;
            rd_save_q          <= '0;
        end else if (ld_alu) begin
            out_is_load_q      <= bus.is_load;
            out_is_store_q     <= bus.is_store;
            out_reg_wr_q       <= bus.reg_wr && !bus.is_store;
            out_flush_q        <= 1'b0;
            out_reg_addr_rd_q  <= bus.reg_addr_rd;
            out_reg_data_rd_q  <= bus.is_store ? opbf : alu_res;
            out_alu_mem_addr_q <= addr_sum[DATA_ADDR_W-1:0];
        end else if (ld_bub) begin
            out_is_load_q  <= 1'b0;
            out_is_store_q <= 1'b0;
            out_reg_wr_q   <= 1'b0;
            out_flush_q    <= 1'b1;
            if (md_start) begin
                rd_save_q <= bus.reg_addr_rd;
            end
        end else if (ld_res) begin
            out_is_load_q     <= 1'b0;
            out_is_store_q    <= 1'b0;
            out_reg_wr_q      <= 1'b1;
            out_flush_q       <= 1'b0;
            out_reg_addr_rd_q <= rd_save_q;
            out_reg_data_rd_q <= md_result;
        end
    end

    assign bus.ex_busy          = (state_q == EX_BUSY) ||
                                  ((state_q == EX_IDLE) && bus.en && !bus.flush && is_md);
    assign bus.out_is_load      = out_is_load_q;
    assign bus.out_is_store     = out_is_store_q;
    assign bus.out_reg_wr       = out_reg_wr_q;
    assign bus.out_flush        = out_flush_q;
    assign bus.out_reg_addr_rd  = out_reg_addr_rd_q;
    assign bus.out_reg_data_rd  = out_reg_data_rd_q;
    assign bus.out_alu_mem_addr = out_alu_mem_addr_q;

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: directed steps plus randomized ops
// compared against a plain-arithmetic reference model.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_stage_ex;
    import stage_ex_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    stage_ex_if bus ();

    stage_ex u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctrl();
        return {28'd0, bus.out_flush, bus.out_reg_wr, bus.out_is_load, bus.out_is_store};
    endfunction

    function automatic logic [31:0] busy();
        return {31'd0, bus.ex_busy};
    endfunction

    function automatic logic [31:0] rdo();
        return {27'd0, bus.out_reg_addr_rd};
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] d,
                                         input logic [31:0] mm, input logic [31:0] wb);
        if (s == 2'd1) return mm;
        if (s == 2'd2) return wb;
        return d;
    endfunction

    // Reference results straight from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << (b % 32);
            ALU_SRL:  return a >> (b % 32);
            ALU_SRA:  return $unsigned($signed(a) >>> (b % 32));
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_MUL:  return a * b;
            ALU_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 32'd0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [1:0] fa, input logic [1:0] fb,
                         input logic ui, input logic ld, input logic st, input logic wr,
                         input logic [4:0] rd);
        bus.alu_op      = op;
        bus.rs1_data    = r1;
        bus.rs2_data    = r2;
        bus.imm         = im;
        bus.fwd_sel_a   = fa;
        bus.fwd_sel_b   = fb;
        bus.use_imm     = ui;
        bus.is_load     = ld;
        bus.is_store    = st;
        bus.reg_wr      = wr;
        bus.reg_addr_rd = rd;
        bus.flush       = 1'b0;
    endtask

    // Issue a mul/div, hold an ADD behind it, and check timing and results.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int n;
        int busy_cnt;
        logic [31:0] exp;
        exp = ref_alu(op, a, b);
        drive(op, a, b, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, rd);
        #1;
        chk({tag, " busy_at_issue"}, busy(), 32'd1);
        tick;
        chk({tag, " bubble"}, ctrl(), 32'b1000);
        drive(ALU_ADD, 32'h11, 32'h22, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
        n = 0;
        busy_cnt = 0;
        while (n < 40 && bus.out_flush === 1'b1) begin
            if (bus.ex_busy === 1'b1) busy_cnt++;
            tick;
            n++;
        end
        chk({tag, " latency"}, n, 32'd32);
        chk({tag, " busy_cycles"}, busy_cnt, 32'd32);
        chk({tag, " result"}, bus.out_reg_data_rd, exp);
        chk({tag, " ctrl"}, ctrl(), 32'b0100);
        chk({tag, " rd"}, rdo(), {27'd0, rd});
        chk({tag, " idle_busy"}, busy(), 32'd0);
        tick;
        chk({tag, " next_add"}, bus.out_reg_data_rd, 32'h33);
        chk({tag, " next_rd"}, rdo(), 32'd9);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] r1, r2, im, mm, wb, a_e, bf_e, b_e, d_e;
        logic [1:0]  fa, fb;
        logic        ui, ld, st, wr;
        logic [4:0]  rd;

        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.stall = 1'b0;
        bus.ffw_MM_data_wr = 32'd0;
        bus.ffw_WB_data_wr = 32'd0;
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #12;
        chk("reset ctrl", ctrl(), 32'b1000);
        chk("reset data", bus.out_reg_data_rd, 32'd0);
        chk("reset addr", bus.out_alu_mem_addr, 32'd0);
        chk("reset rd", rdo(), 32'd0);
        chk("reset busy", busy(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Forwarded ADD from the MM stage.
        bus.ffw_MM_data_wr = 32'h10;
        drive(ALU_ADD, 32'hDEAD, 32'd5, 32'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
        tick;
        chk("fwd add data", bus.out_reg_data_rd, 32'h15);
        chk("fwd add ctrl", ctrl(), 32'b0100);
        chk("fwd add rd", rdo(), 32'd3);

        drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        tick;
        chk("slt", bus.out_reg_data_rd, 32'd1);
        drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        tick;
        chk("sltu", bus.out_reg_data_rd, 32'd0);

        // Store: address from A+imm, data from Bf, no register write.
        drive(ALU_ADD, 32'h100, 32'hAB, 32'd8, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
        tick;
        chk("store addr", bus.out_alu_mem_addr, 32'h108);
        chk("store data", bus.out_reg_data_rd, 32'hAB);
        chk("store ctrl", ctrl(), 32'b0001);

        // Stall in IDLE holds everything.
        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
        bus.stall = 1'b1;
        tick;
        chk("stall hold data", bus.out_reg_data_rd, 32'hAB);
        chk("stall hold ctrl", ctrl(), 32'b0001);
        bus.stall = 1'b0;

        // Flushed mul: bubble out, nothing started.
        drive(ALU_MUL, 32'd3, 32'd4, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
        bus.flush = 1'b1;
        #1;
        chk("flush busy comb", busy(), 32'd0);
        tick;
        chk("flush ctrl", ctrl(), 32'b1000);
        chk("flush busy after", busy(), 32'd0);

        // Randomized single-cycle ops.
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 9));
            r1 = $urandom;
            r2 = $urandom;
            im = $urandom;
            mm = $urandom;
            wb = $urandom;
            fa = 2'($urandom_range(0, 3));
            fb = 2'($urandom_range(0, 3));
            ui = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0);
            ld = st ? 1'b0 : 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            a_e  = pick(fa, r1, mm, wb);
            bf_e = pick(fb, r2, mm, wb);
            b_e  = ui ? im : bf_e;
            d_e  = st ? bf_e : ref_alu(op, a_e, b_e);
            bus.ffw_MM_data_wr = mm;
            bus.ffw_WB_data_wr = wb;
            drive(op, r1, r2, im, fa, fb, ui, ld, st, wr, rd);
            tick;
            chk($sformatf("rand%0d data op%0d", i, op), bus.out_reg_data_rd, d_e);
            chk($sformatf("rand%0d ctrl", i), ctrl(), {28'd0, 1'b0, wr & ~st, ld, st});
            chk($sformatf("rand%0d addr", i), bus.out_alu_mem_addr, a_e + im);
            chk($sformatf("rand%0d rd", i), rdo(), {27'd0, rd});
        end

        // Directed mul/div.
        run_md("mul 7x6", ALU_MUL, 32'd7, 32'd6, 5'd10);
        run_md("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 5'd11);
        run_md("remu 100/7", ALU_REMU, 32'd100, 32'd7, 5'd12);
        run_md("divu x/0", ALU_DIVU, 32'h1234_5678, 32'd0, 5'd13);
        run_md("remu 9/0", ALU_REMU, 32'd9, 32'd0, 5'd14);

        // Randomized mul/div, including small and zero divisors.
        for (int i = 0; i < 6; i++) begin
            op = 4'($urandom_range(10, 12));
            r1 = $urandom;
            r2 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            run_md($sformatf("rmd%0d op%0d", i, op), op, r1, r2, 5'($urandom_range(0, 31)));
        end

        // Stall at the final count delays the result by exactly 3 edges.
        drive(ALU_MUL, 32'h1234, 32'h10, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd20);
        tick;
        drive(ALU_ADD, 32'h11, 32'h22, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
        repeat (31) tick;
        chk("stall pre ctrl", ctrl(), 32'b1000);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("stall final hold%0d", i), ctrl(), 32'b1000);
        end
        bus.stall = 1'b0;
        tick;
        chk("stall result", bus.out_reg_data_rd, 32'h12340);
        chk("stall result ctrl", ctrl(), 32'b0100);
        chk("stall result rd", rdo(), 32'd20);
        tick;

        // en low mid-busy freezes the iteration count.
        drive(ALU_DIVU, 32'd1000, 32'd10, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd21);
        tick;
        drive(ALU_ADD, 32'h11, 32'h22, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
        repeat (10) tick;
        bus.en = 1'b0;
        repeat (5) tick;
        chk("en low busy", busy(), 32'd1);
        chk("en low ctrl", ctrl(), 32'b1000);
        bus.en = 1'b1;
        repeat (21) tick;
        chk("en resume not yet", ctrl(), 32'b1000);
        tick;
        chk("en resume result", bus.out_reg_data_rd, 32'd100);
        chk("en resume ctrl", ctrl(), 32'b0100);
        tick;

        // Reset mid-busy discards the mul/div.
        drive(ALU_MUL, 32'd5, 32'd5, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd22);
        tick;
        drive(ALU_ADD, 32'h11, 32'h22, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
        repeat (5) tick;
        rst_n = 1'b0;
        #1;
        chk("midreset busy", busy(), 32'd0);
        chk("midreset ctrl", ctrl(), 32'b1000);
        chk("midreset data", bus.out_reg_data_rd, 32'd0);
        chk("midreset addr", bus.out_alu_mem_addr, 32'd0);
        chk("midreset rd", rdo(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("post reset add", bus.out_reg_data_rd, 32'h33);
        chk("post reset ctrl", ctrl(), 32'b0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
